uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Byte-level UART receive engine: it recovers 8N1 frames from a registered serial line. Bit timing comes from the run-time `baud_edge` divisor, and each bit is sampled at mid-bit. The engine validates the start bit, checks the stop bit, and presents each byte on a ready/valid output port. It sits behind the UART wrapper's input register and is the receive-side counterpart of the transmitter on the same `baud_edge` bus. It reports framing errors and overruns to the CSR block.

## Interface
- `CLOCK_FREQ`, default 125_000_000: system clock in Hz. Used only to size `BAUD_BITS`.
- `MIN_BDRT`, default 9_600: lowest supported baud rate.
- `BAUD_BITS`, default `$clog2((CLOCK_FREQ+(MIN_BDRT/2)-1)/(MIN_BDRT/2))`: width of the divisor and bit-period counter.
- `clk` input, 1 bit: system clock. Everything is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `baud_edge` input, `BAUD_BITS` bits: clk cycles per bit period. Legal values are ≥ 4. Changes only while the line is idle.
- `serial_in` input, 1 bit: serial line, already registered by the parent. Idle level is 1.
- `data_out` output, 8 bits: received byte.
- `data_out_valid` output, 1 bit: `data_out` holds an unconsumed byte.
- `data_out_ready` input, 1 bit: consumer accepts the byte.
- `frame_error` output, 1 bit: one-cycle pulse when the stop bit (or parity) is bad.
- `overrun` output, 1 bit: one-cycle pulse when a good byte is dropped because the previous byte is unconsumed.

## Operation
- **Reset values:** state IDLE; `data_out`=0x00; `data_out_valid`, `frame_error` and `overrun` all 0; bit-period and bit counters 0.
- **Frame format:** start bit (0), 8 data bits LSB first, [parity], stop bit (1).
- **IDLE:** when `serial_in`=0, go to START and clear `clk_cnt`.
- **START:** `clk_cnt` increments each cycle. At `clk_cnt == (baud_edge>>1)-1`, sample `serial_in`:
  - 1 means a glitch: return to IDLE with no flags raised.
  - 0 means a valid start: clear `clk_cnt` and `bit_cnt`, go to DATA.
- **DATA:** at `clk_cnt == baud_edge-1`, sample into `shift[bit_cnt]` and clear `clk_cnt`. After `bit_cnt`=7, go to PARITY if enabled, else to STOP.
- **STOP:** sample at `clk_cnt == baud_edge-1`.
  - Stop bit 1 with no parity error: deliver the byte and go straight to IDLE. The early return half a bit before the stop bit ends allows resync on back-to-back frames.
  - Stop bit 0 or a parity error: pulse `frame_error`, discard the byte, go to BREAK.
- **BREAK:** wait until `serial_in`=1, then go to IDLE. A line held low is never re-detected as a start bit.
- **Delivery:**
  - `data_out_valid`=0, or `data_out_ready`=1 in the same cycle: load `data_out` and set valid.
  - Otherwise: keep the old `data_out`, drop the new byte, pulse `overrun`.
- **Handshake:** valid clears on a cycle with `data_out_ready`=1 unless a new byte is delivered that same cycle. `data_out` is stable while valid is high.
- **Mid-frame reset:** returns to IDLE immediately with all outputs at reset values. The rest of the frame is treated as a line event: a 0 may start a new frame; a false start is rejected at mid-bit.

## Timing
- Let T0 be the cycle in which IDLE registers `serial_in`=0, and let h = `baud_edge>>1`.
- Start sample: T0+h. Data bit k (k=0..7) sample: T0+h+(k+1)·`baud_edge`.
- Stop sample: T0+h+9·`baud_edge`, or +10·`baud_edge` with parity.
- `data_out_valid` / `frame_error` / `overrun` change at stop sample +1 cycle.
- Accepted bit-rate error is ±(h/`baud_edge`)/10 of a bit per frame; no oversampling majority vote.
- Throughput: one byte per frame time. No internal buffering beyond the single output register.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit follows D7 and is sampled at `clk_cnt == baud_edge-1` in state PARITY. A parity mismatch is reported exactly like a bad stop bit (`frame_error` pulse, byte discarded).
- Not defined: there is no PARITY state and the frame is 8N1.

## Test plan
- **Clean frame:** `baud_edge`=16, frame 0xA5, `data_out_ready`=1. `data_out`=0xA5 and valid rises at T0+153 for exactly 1 cycle; no flags.
- **Glitch:** `baud_edge`=16, `serial_in` low for 3 cycles then high. No valid and no `frame_error`; state back in IDLE by T0+8.
- **Bad stop bit:** 0x3C with stop bit 0, line held low 40 more cycles. One `frame_error` pulse, no valid; next frame 0x55 after the line returns high is received correctly.
- **Overrun:** 0x11 then 0x22 back-to-back with `data_out_ready`=0. `data_out` stays 0x11 and `overrun` pulses once. Raising ready then delivers 0x11 only.
- **Reset mid-frame:** `reset` asserted at data bit 4 of 0xF0. The next cycle has all outputs at reset values; the following clean frame 0x81 is received.
- **Parity error** (`UART_RX_PARITY_EN` only): frame 0x07 with parity bit 0. `frame_error` pulses and no valid is raised.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Byte output port of the UART receive engine: ready/valid data plus status pulses.
interface uart_rx_sampler_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output frame_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  frame_error,
        input  overrun,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receive engine, mid-bit sampling driven by the baud_edge divisor.
// Define UART_RX_PARITY_EN to add an even-parity bit after D7.
module uart_rx_sampler #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned MIN_BDRT   = 9_600,
    parameter int unsigned BAUD_BITS  = $clog2((CLOCK_FREQ + (MIN_BDRT / 2) - 1) / (MIN_BDRT / 2))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BAUD_BITS-1:0] baud_edge,
    input  logic                 serial_in,
    uart_rx_sampler_if.master    rx
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [BAUD_BITS-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 par_err_c;
    logic                 deliver_c;
    logic [BAUD_BITS-1:0] half_m1_c;
    logic [BAUD_BITS-1:0] full_m1_c;

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_err_c = par_err_q;
`else
    assign par_err_c = 1'b0;
`endif

    assign half_m1_c = (baud_edge >> 1) - BAUD_BITS'(1);
    assign full_m1_c = baud_edge - BAUD_BITS'(1);

    // Next-state, bit sampling and output-register update
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + BAUD_BITS'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q & ~rx.data_out_ready;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        deliver_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!serial_in) state_d = S_START;
            end
            S_START: begin
                if (clk_cnt_q == half_m1_c) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = serial_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == full_m1_c) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = serial_in;
                    bit_cnt_d          = bit_cnt_q + 3'(1);
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_q == full_m1_c) begin
                    clk_cnt_d = '0;
                    par_err_d = (^shift_q) ^ serial_in;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed
                if (clk_cnt_q == full_m1_c) begin
                    clk_cnt_d = '0;
                    if (serial_in && !par_err_c) begin
                        deliver_c = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_d = '0;
                if (serial_in) state_d = S_IDLE;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        if (deliver_c) begin
            if (!valid_q || rx.data_out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign rx.data_out       = data_q;
    assign rx.data_out_valid = valid_q;
    assign rx.frame_error    = fe_q;
    assign rx.overrun        = ov_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: bytes queued when framed, checked on handshake.
module tb_uart_rx_sampler;
    localparam int B = 16;
`ifdef UART_RX_PARITY_EN
    localparam int RISE = 153 + B;
`else
    localparam int RISE = 153;
`endif

    logic        clk;
    logic        reset;
    logic [14:0] baud_edge;
    logic        serial_in;

    uart_rx_sampler_if rx_if ();

    uart_rx_sampler dut (
        .clk       (clk),
        .reset     (reset),
        .baud_edge (baud_edge),
        .serial_in (serial_in),
        .rx        (rx_if)
    );

    int         checks;
    int         failures;
    int         fe_cnt;
    int         ov_cnt;
    int         fe_exp;
    int         ov_exp;
    logic [7:0] exp_q[$];
    logic       prev_valid;
    logic       prev_take;
    logic [7:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        serial_in = 1'b0;
        repeat (B) tick();
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (B) tick();
        end
`ifdef UART_RX_PARITY_EN
        serial_in = (^b) ^ ~par_ok;
        repeat (B) tick();
`endif
        serial_in = stop;
        repeat (B) tick();
    endtask

    // Output monitor: scoreboard pops on handshake, hold check, flag pulse counters
    always @(negedge clk) begin
        if (prev_valid && !prev_take && rx_if.data_out_valid)
            chk("hold_data", 32'(rx_if.data_out), 32'(prev_data));
        if (rx_if.data_out_valid && rx_if.data_out_ready) begin
            if (exp_q.size() == 0) chk("extra_byte", 32'(rx_if.data_out), 32'h100);
            else                   chk("rx_byte", 32'(rx_if.data_out), 32'(exp_q.pop_front()));
        end
        fe_cnt += int'(rx_if.frame_error);
        ov_cnt += int'(rx_if.overrun);
        prev_valid = rx_if.data_out_valid;
        prev_take  = rx_if.data_out_valid & rx_if.data_out_ready;
        prev_data  = rx_if.data_out;
    end

    initial begin
        checks = 0; failures = 0; fe_cnt = 0; ov_cnt = 0; fe_exp = 0; ov_exp = 0;
        prev_valid = 1'b0; prev_take = 1'b0; prev_data = 8'h00;
        reset = 1'b1; serial_in = 1'b1; baud_edge = 15'(B);
        rx_if.data_out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_data", 32'(rx_if.data_out), 32'h00);
        chk("rst_valid", 32'(rx_if.data_out_valid), 32'h0);
        chk("rst_fe", 32'(rx_if.frame_error), 32'h0);
        chk("rst_ov", 32'(rx_if.overrun), 32'h0);
        reset = 1'b0;
        idle(5);

        // Clean frame with exact valid timing
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (RISE - 1) tick();
                chk("clean_pre", 32'(rx_if.data_out_valid), 32'h0);
                tick();
                chk("clean_rise", 32'(rx_if.data_out_valid), 32'h1);
                chk("clean_data", 32'(rx_if.data_out), 32'hA5);
                tick();
                chk("clean_fall", 32'(rx_if.data_out_valid), 32'h0);
            end
        join
        idle(10);
        chk("clean_fe", 32'(fe_cnt), 32'(fe_exp));

        // Glitch: short low pulse is rejected
        serial_in = 1'b0;
        repeat (3) tick();
        idle(40);
        chk("glitch_fe", 32'(fe_cnt), 32'(fe_exp));
        chk("glitch_valid", 32'(rx_if.data_out_valid), 32'h0);

        // Bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (40) tick();
        fe_exp++;
        idle(20);
        chk("badstop_fe", 32'(fe_cnt), 32'(fe_exp));
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(10);
        chk("badstop_q", 32'(exp_q.size()), 32'h0);

        // Overrun: second byte dropped while first is unconsumed
        rx_if.data_out_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        ov_exp++;
        idle(10);
        chk("ovr_data", 32'(rx_if.data_out), 32'h11);
        chk("ovr_cnt", 32'(ov_cnt), 32'(ov_exp));
        rx_if.data_out_ready = 1'b1;
        tick();
        tick();
        chk("ovr_drain", 32'(rx_if.data_out_valid), 32'h0);
        chk("ovr_q", 32'(exp_q.size()), 32'h0);

        // Reset mid-frame with a byte pending
        rx_if.data_out_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(5);
        chk("pend_valid", 32'(rx_if.data_out_valid), 32'h1);
        serial_in = 1'b0;
        repeat (5 * B) tick();
        serial_in = 1'b1;
        repeat (B / 2) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("mrst_data", 32'(rx_if.data_out), 32'h00);
        chk("mrst_valid", 32'(rx_if.data_out_valid), 32'h0);
        chk("mrst_fe", 32'(rx_if.frame_error), 32'h0);
        chk("mrst_ov", 32'(rx_if.overrun), 32'h0);
        reset = 1'b0;
        idle(5 * B);
        rx_if.data_out_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(10);
        chk("mrst_q", 32'(exp_q.size()), 32'h0);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch reported as framing error
        send_frame(8'h07, 1'b1, 1'b0);
        fe_exp++;
        idle(20);
        chk("par_fe", 32'(fe_cnt), 32'(fe_exp));
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        chk("par_good_q", 32'(exp_q.size()), 32'h0);
`endif

        idle(20);
        chk("final_q", 32'(exp_q.size()), 32'h0);
        chk("final_fe", 32'(fe_cnt), 32'(fe_exp));
        chk("final_ov", 32'(ov_cnt), 32'(ov_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
